// File: rtl/permutation_round_ctrl_pkg.sv
// Shared types and helpers for the ASCON permutation round controller:
// state type, mode/FSM encodings, round count and round constants.
package permutation_round_ctrl_pkg;

  localparam int NB_ROUNDS = 12;

  // x0 is word 0, x4 is word 4; each word is 64 bits.
  typedef logic [4:0][63:0] type_state;

  typedef enum logic [1:0] {
    MODE_P12 = 2'b00,
    MODE_P8  = 2'b01,
    MODE_P6  = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } fsm_t;

  // First round index for a permutation; the reserved code 11 runs as p12.
  function automatic logic [3:0] start_round(input logic [1:0] mode);
    case (mode)
      MODE_P8: start_round = 4'd4;
      MODE_P6: start_round = 4'd6;
      default: start_round = 4'd0;
    endcase
  endfunction

  function automatic logic [63:0] round_constant(input logic [3:0] round);
    logic [3:0] hi;
    hi = 4'hF - round;
    round_constant = {56'h0, hi, round};
  endfunction

endpackage

// File: rtl/permutation_round_ctrl_round_counter.sv
// Round index counter: loadable start index, advances on enable and
// saturates at the last round index.
module permutation_round_ctrl_round_counter
  import permutation_round_ctrl_pkg::*;
#(
  parameter int NB_ROUNDS_MAX = NB_ROUNDS
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic [3:0] count_o,
  output logic       last_o
);

  localparam logic [3:0] LAST_ROUND = 4'(NB_ROUNDS_MAX - 1);

  logic [3:0] count_q, count_d;

  assign last_o  = (count_q == LAST_ROUND);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && !last_o) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/permutation_round_ctrl.sv
// Sequential front end of the ASCON permutation: state register, round
// index and the IDLE/RUN/DONE sequencing for p12, p8 and p6.
module permutation_round_ctrl
  import permutation_round_ctrl_pkg::*;
#(
  parameter int NB_ROUNDS_MAX = NB_ROUNDS
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  input  type_state  state_i,
  input  type_state  round_state_i,
  output type_state  state_o,
  output logic [3:0] round_o,
  output logic       ready_o,
  output logic       busy_o,
  output logic       done_o
);

  fsm_t      fsm_q, fsm_d;
  type_state state_q, state_d;
  logic      cnt_load, cnt_en, cnt_last;
  logic [3:0] cnt_value;

  permutation_round_ctrl_round_counter #(
    .NB_ROUNDS_MAX(NB_ROUNDS_MAX)
  ) u_round_counter (
    .clock_i   (clock_i),
    .resetb_i  (resetb_i),
    .load_i    (cnt_load),
    .load_val_i(start_round(mode_i)),
    .en_i      (cnt_en),
    .count_o   (cnt_value),
    .last_o    (cnt_last)
  );

  // Handshake: ready_o marks the only cycles in which start_i is taken;
  // start_i elsewhere is dropped, not queued.
  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          state_d  = state_i;
          cnt_load = 1'b1;
          fsm_d    = RUN;
        end
      end
      RUN: begin
        state_d = round_state_i;
        cnt_en  = 1'b1;
        if (cnt_last) begin
          fsm_d = DONE;
        end
      end
      DONE: fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
  assign round_o = cnt_value;
  assign ready_o = (fsm_q == IDLE);
  assign busy_o  = (fsm_q == RUN);
  assign done_o  = (fsm_q == DONE);

endmodule

// File: tb/tb_permutation_round_ctrl.sv
// Bench for permutation_round_ctrl: constant-adder loopback, round-index and
// result scoreboard, latency, hold-start, mode and reset cases.
module tb_permutation_round_ctrl;
  import permutation_round_ctrl_pkg::*;

  logic       clock_i;
  logic       resetb_i;
  logic       start_i;
  logic [1:0] mode_i;
  type_state  state_i;
  type_state  round_state_i;
  type_state  state_o;
  logic [3:0] round_o;
  logic       ready_o;
  logic       busy_o;
  logic       done_o;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int runs_exp = 0;
  bit sb_en = 1'b1;

  logic [319:0] exp_state_q[$];
  logic [3:0]   exp_round_q[$];

  logic [7:0] rc_tab [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                              8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

  permutation_round_ctrl dut (
    .clock_i      (clock_i),
    .resetb_i     (resetb_i),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .state_i      (state_i),
    .round_state_i(round_state_i),
    .state_o      (state_o),
    .round_o      (round_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  // clock / reset
  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  // Loopback emulating constant adder only (S-box/diffusion as identity).
  always_comb begin
    round_state_i = state_o;
    if (round_o < 4'd12) begin
      round_state_i[2][7:0] = state_o[2][7:0] ^ rc_tab[round_o];
    end
  end

  task automatic check(input string tag, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic type_state model_perm(input type_state init, input int sr);
    type_state s;
    s = init;
    for (int r = sr; r < 12; r++) s[2][7:0] = s[2][7:0] ^ rc_tab[r];
    return s;
  endfunction

  function automatic type_state rand_state(input bit fixed_x2);
    type_state s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
    if (fixed_x2) s[2] = 64'h0000_0000_0000_00AB;
    return s;
  endfunction

  // scoreboard monitor
  always @(negedge clock_i) begin
    if (resetb_i) begin
      check("busy_done_excl", {319'h0, busy_o & done_o}, 320'h0);
      if (busy_o && sb_en) begin
        if (exp_round_q.size() == 0) check("round_unexp", exp_round_q.size(), 1);
        else check("round", round_o, exp_round_q.pop_front());
      end
      if (done_o) begin
        done_cnt++;
        if (sb_en) begin
          if (exp_state_q.size() == 0) check("done_unexp", exp_state_q.size(), 1);
          else check("final_state", state_o, exp_state_q.pop_front());
        end
      end
    end
  end

  task automatic run_perm(input logic [1:0] mode, input type_state init,
                          input bit keep_start, input bit toggle_mode);
    int sr, n, cyc, guard;
    bit seen;
    type_state expv;
    sr = (mode == 2'b01) ? 4 : (mode == 2'b10) ? 6 : 0;
    n = 12 - sr;
    expv = model_perm(init, sr);
    guard = 0;
    while (!ready_o && guard < 30) begin
      @(negedge clock_i);
      guard++;
    end
    check("ready_wait", {319'h0, ready_o}, 320'h1);
    for (int r = sr; r < 12; r++) exp_round_q.push_back(4'(r));
    exp_state_q.push_back(expv);
    runs_exp++;
    mode_i  = mode;
    state_i = init;
    start_i = 1'b1;
    @(posedge clock_i);
    #1;
    if (!keep_start) start_i = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clock_i);
      cyc++;
      if (toggle_mode && cyc == 2) mode_i = 2'b10;
      if (done_o) seen = 1'b1;
    end
    check("done_latency", cyc, n + 1);
    @(negedge clock_i);
    check("done_one_cycle", {319'h0, done_o}, 320'h0);
    check("ready_return", {319'h0, ready_o}, 320'h1);
    check("result_hold", state_o, expv);
  endtask

  initial begin
    type_state pat;
    int guard;
    resetb_i = 1'b0;
    start_i  = 1'b0;
    mode_i   = 2'b00;
    state_i  = '0;
    repeat (3) @(negedge clock_i);
    check("rst_state", state_o, 320'h0);
    check("rst_round", round_o, 4'd0);
    check("rst_ready", {319'h0, ready_o}, 320'h1);
    check("rst_busy", {319'h0, busy_o}, 320'h0);
    check("rst_done", {319'h0, done_o}, 320'h0);
    resetb_i = 1'b1;
    @(negedge clock_i);

    pat = rand_state(1'b1);
    run_perm(2'b00, pat, 1'b0, 1'b0);          // p12
    check("p12_x2", state_o[2][7:0], 8'hAB);
    run_perm(2'b10, pat, 1'b0, 1'b0);          // p6
    check("p6_x2", state_o[2][7:0], 8'hBA);
    run_perm(2'b01, pat, 1'b0, 1'b1);          // p8, mode toggled mid-run
    check("p8_x2", state_o[2][7:0], 8'hAB);
    run_perm(2'b11, pat, 1'b0, 1'b0);          // reserved -> p12
    run_perm(2'b10, pat, 1'b1, 1'b0);          // start held high
    run_perm(2'b10, pat, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_perm(2'($urandom_range(0, 3)), rand_state(1'b0), 1'b0, 1'b0);
    end
    check("done_count", done_cnt, runs_exp);

    // asynchronous reset at round 5 of a p12 run
    sb_en = 1'b0;
    mode_i = 2'b00;
    state_i = rand_state(1'b0);
    start_i = 1'b1;
    @(posedge clock_i);
    #1 start_i = 1'b0;
    guard = 0;
    while (!(busy_o && round_o == 4'd5) && guard < 20) begin
      @(negedge clock_i);
      guard++;
    end
    check("reach_round5", round_o, 4'd5);
    #2 resetb_i = 1'b0;
    #1;
    check("arst_state", state_o, 320'h0);
    check("arst_round", round_o, 4'd0);
    check("arst_ready", {319'h0, ready_o}, 320'h1);
    check("arst_busy", {319'h0, busy_o}, 320'h0);
    repeat (3) @(negedge clock_i);
    resetb_i = 1'b1;
    repeat (15) @(negedge clock_i);
    check("arst_no_done", done_cnt, runs_exp);
    check("arst_idle", {319'h0, ready_o}, 320'h1);
    sb_en = 1'b1;

    check("sb_round_drain", exp_round_q.size(), 0);
    check("sb_state_drain", exp_state_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/permutation_round_ctrl.md
Name: permutation_round_ctrl

Overview:
Sequential front end of the ASCON permutation. It holds the 320-bit state register and generates the 4-bit round index. It drives the constant adder directly: state_o goes to constadd_addend_i and round_o goes to round_i. It loops the diffusion-layer output back into the register once per round. It runs p12, p8 or p6 on a start pulse and flags completion.

Parameters:
NB_ROUNDS_MAX, 12, total ASCON rounds; also the exclusive upper bound of the round index (last index is NB_ROUNDS_MAX-1 = 11)

Ports:
clock_i  input  1  system clock, rising edge
resetb_i  input  1  asynchronous active-low reset
start_i  input  1  start request; sampled only in IDLE
mode_i  input  2  permutation select: 00=p12, 01=p8, 10=p6, 11=p12 (reserved, treated as p12)
state_i  input  320 (type_state)  initial state, loaded on an accepted start
round_state_i  input  320 (type_state)  state after one full round (linear diffusion output), captured each RUN cycle
state_o  output  320 (type_state)  current state register; feeds the constant adder
round_o  output  4  current round index; feeds the constant adder round_i
ready_o  output  1  high in IDLE only
busy_o  output  1  high in RUN only
done_o  output  1  one-cycle pulse in DONE; state_o then holds the permutation result

Behaviour:
- Reset (resetb_i=0, asynchronous): FSM=IDLE, state register=0, round counter=0, ready_o=1, busy_o=0, done_o=0. Reset mid-RUN aborts immediately; no done_o is produced.
- FSM states: IDLE -> RUN -> DONE -> IDLE. Outputs are Moore; done_o and busy_o are never high together.
- IDLE:
  - ready_o=1.
  - On start_i=1: state register <= state_i; round counter <= 12-N, where N = 12/8/6 for p12/p8/p6, so the start index is 0/4/6. Go to RUN.
  - On start_i=0: register and counter hold.
- RUN:
  - busy_o=1; round_o = counter; state_o = register.
  - Each cycle: register <= round_state_i.
  - If counter==11: go to DONE with the counter holding 11. Otherwise counter <= counter+1.
- DONE: done_o=1 for exactly one cycle; register holds; unconditionally go to IDLE.
- Latency: start sampled at edge t. Rounds occupy cycles t+1..t+N. done_o is high in cycle t+N+1. ready_o returns in cycle t+N+2.
- Throughput: a new start is accepted at the earliest in cycle t+N+2.
- start_i in RUN or DONE is ignored and not queued.
- mode_i is sampled only with an accepted start; changes during RUN have no effect.
- state_o and round_o hold their last values in IDLE, so the result stays stable until the next start.
- The counter never exceeds 11 and never wraps. With 4 bits, values 12..15 are unreachable.
- Combinational path assumption: state_o -> constant adder -> substitution -> diffusion -> round_state_i is one cycle. No registers in this block other than the FSM, counter and state.

Decomposition:
- ascon_pack additions:
  - typedef enum for mode: MODE_P12, MODE_P8, MODE_P6.
  - typedef enum for FSM state: IDLE, RUN, DONE.
  - constant NB_ROUNDS=12.
  - function start_round(mode) returning 0/4/6.
- type_state and round_constant are reused unchanged from ascon_pack.
- One natural sub-module: round_counter (load value, enable, terminal flag at 11). The FSM and state register stay in the top.

Test Plan:
- Reset mid-RUN (p12, pull resetb_i low at round 5) -> asynchronously IDLE, state_o=0, round_o=0, ready_o=1, no done_o.
- p12, loopback round_state_i = constant adder output, state_i x2=0x...00AB -> round_o steps 0..11 over 12 cycles; done_o at t+13; final x2[7:0]=0xAB (XOR of all 12 constants = 0x00); x0, x1, x3, x4 unchanged.
- p6, same loopback and state_i -> round_o 6..11; done_o at t+7; final x2[7:0]=0xBA (0xAB^0x11).
- p8 with mode_i toggled to 10 mid-RUN, same loopback -> round_o 4..11 (8 rounds); mode change ignored; done_o at t+9.
- start_i held high continuously through a p6 run -> exactly one run; next load at t+8; done_o pulses exactly one cycle each run.
- mode_i=11 -> behaves as p12 (first round_o=0, done_o at t+13).
